// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction unit: branch type codes,
// 2-bit BHT counter states and the saturating counter step function.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_RSVD = 3'd7
  } branch_type_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  // One step of a 2-bit saturating counter toward the resolved outcome.
  function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
    bht_state_t nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation from the ALU subtract flags.
// Also reports whether the type code names a real conditional branch.
module branch_cond_eval
  import branch_pkg::*;
(
  input  branch_type_t branch_type,
  input  logic         zero_flag,
  input  logic         neg_flag,
  input  logic         ovf_flag,
  input  logic         carry_flag,
  output logic         cond_taken,
  output logic         is_branch
);

  // Decode the branch type and pick the matching flag expression.
  always_comb begin
    cond_taken = 1'b0;
    is_branch  = 1'b1;
    case (branch_type)
      BR_BEQ:  cond_taken = zero_flag;
      BR_BNE:  cond_taken = ~zero_flag;
      BR_BLT:  cond_taken = neg_flag ^ ovf_flag;
      BR_BGE:  cond_taken = ~(neg_flag ^ ovf_flag);
      BR_BLTU: cond_taken = ~carry_flag;
      BR_BGEU: cond_taken = carry_flag;
      BR_NONE: begin
        cond_taken = 1'b0;
        is_branch  = 1'b0;
      end
      default: begin
        cond_taken = 1'b0;
        is_branch  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// PC word bits, a combinational lookup port, a registered resolve port and
// saturating statistics counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [2:0]       branch_type,
  input  logic             res_pred_taken,
  input  logic             ALU_zero_flag,
  input  logic             ALU_neg_flag,
  input  logic             ALU_ovf_flag,
  input  logic             ALU_carry_flag,
  input  logic             stats_clear,
  output logic             out_valid,
  output logic             b_out,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int               DEPTH   = 1 << IDX_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  bht_state_t          bht [DEPTH];
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic [1:0]          pred_entry;
  branch_type_t        btype;
  logic                cond_taken;
  logic                is_branch;
  logic                real_resolve;
  logic                res_mispredict;
  logic [CNT_W-1:0]    branch_count_next;
  logic [CNT_W-1:0]    mispredict_count_next;
  logic                unused_pc_bits;

  // Byte offset and upper PC bits do not take part in indexing.
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_BITS+2], pred_pc[1:0],
                            res_pc[XLEN-1:IDX_BITS+2], res_pc[1:0]};

  assign pred_idx = pred_pc[IDX_BITS+1:2];
  assign res_idx  = res_pc[IDX_BITS+1:2];
  assign btype    = branch_type_t'(branch_type);

  // Lookup reads the stored entry directly, so a same-cycle update is not seen.
  assign pred_entry = bht[pred_idx];
  assign pred_taken = pred_entry[1];

  branch_cond_eval u_cond (
    .branch_type (btype),
    .zero_flag   (ALU_zero_flag),
    .neg_flag    (ALU_neg_flag),
    .ovf_flag    (ALU_ovf_flag),
    .carry_flag  (ALU_carry_flag),
    .cond_taken  (cond_taken),
    .is_branch   (is_branch)
  );

  assign real_resolve   = res_valid & is_branch;
  assign res_mispredict = real_resolve & (cond_taken ^ res_pred_taken);

  // Table update: reset every entry to weakly-not-taken, else train on real resolves.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht[i] <= WNT;
      end
    end else if (real_resolve) begin
      bht[res_idx] <= bht_next(bht[res_idx], cond_taken);
    end
  end

  // Resolve result register; non-branch resolves report valid with zero outcome.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      out_valid  <= 1'b0;
      b_out      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      out_valid  <= res_valid;
      b_out      <= real_resolve & cond_taken;
      mispredict <= res_mispredict;
    end
  end

  // Statistics next-state: clear wins over increment, increments saturate.
  always_comb begin
    branch_count_next     = branch_count;
    mispredict_count_next = mispredict_count;
    if (stats_clear) begin
      branch_count_next     = {CNT_W{1'b0}};
      mispredict_count_next = {CNT_W{1'b0}};
    end else begin
      if (real_resolve && (branch_count != CNT_MAX)) begin
        branch_count_next = branch_count + CNT_ONE;
      end else begin
        branch_count_next = branch_count;
      end
      if (res_mispredict && (mispredict_count != CNT_MAX)) begin
        mispredict_count_next = mispredict_count + CNT_ONE;
      end else begin
        mispredict_count_next = mispredict_count;
      end
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      branch_count     <= {CNT_W{1'b0}};
      mispredict_count <= {CNT_W{1'b0}};
    end else begin
      branch_count     <= branch_count_next;
      mispredict_count <= mispredict_count_next;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a behavioural model compared on
// every falling edge, plus directed literal expectations.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] pred_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [2:0]  branch_type;
  logic        res_pred_taken;
  logic        zf, nf, vf, cf;
  logic        stats_clear;

  logic        pred_taken, out_valid, b_out, mispredict;
  logic [15:0] branch_count, mispredict_count;
  logic        pred_taken4, out_valid4, b_out4, mispredict4;
  logic [3:0]  branch_count4, mispredict_count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_predict_unit u_dut (
    .clk(clk), .nrst(nrst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .branch_type(branch_type),
    .res_pred_taken(res_pred_taken), .ALU_zero_flag(zf), .ALU_neg_flag(nf),
    .ALU_ovf_flag(vf), .ALU_carry_flag(cf), .stats_clear(stats_clear),
    .out_valid(out_valid), .b_out(b_out), .mispredict(mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predict_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .pred_pc(pred_pc), .pred_taken(pred_taken4),
    .res_valid(res_valid), .res_pc(res_pc), .branch_type(branch_type),
    .res_pred_taken(res_pred_taken), .ALU_zero_flag(zf), .ALU_neg_flag(nf),
    .ALU_ovf_flag(vf), .ALU_carry_flag(cf), .stats_clear(stats_clear),
    .out_valid(out_valid4), .b_out(b_out4), .mispredict(mispredict4),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_bht [16];
  bit m_ready = 1'b0;
  bit m_ov, m_b, m_mis;
  int m_bc, m_mc, m_bc4, m_mc4;

  function automatic bit outcome(input int t, input bit z, input bit n, input bit o, input bit c);
    case (t)
      1: return z;
      2: return !z;
      3: return n != o;
      4: return n == o;
      5: return !c;
      6: return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Model state advance at every rising edge from the inputs held across it.
  always @(posedge clk) begin
    bit real_br, tk;
    int ix;
    if (!nrst) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_ov = 0; m_b = 0; m_mis = 0;
      m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
      m_ready = 1'b1;
    end else begin
      real_br = res_valid && (branch_type >= 3'd1) && (branch_type <= 3'd6);
      tk      = outcome(int'(branch_type), zf, nf, vf, cf);
      ix      = int'((res_pc >> 2) % 16);
      m_ov  = res_valid;
      m_b   = real_br && tk;
      m_mis = real_br && (tk != res_pred_taken);
      if (real_br) m_bht[ix] = tk ? ((m_bht[ix] == 3) ? 3 : m_bht[ix] + 1)
                                  : ((m_bht[ix] == 0) ? 0 : m_bht[ix] - 1);
      if (stats_clear) begin
        m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
      end else begin
        if (real_br) begin m_bc = sat_inc(m_bc, 65535); m_bc4 = sat_inc(m_bc4, 15); end
        if (m_mis)   begin m_mc = sat_inc(m_mc, 65535); m_mc4 = sat_inc(m_mc4, 15); end
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("pred_taken", pred_taken, m_bht[(pred_pc >> 2) % 16] >= 2);
      chk("pred_taken_w4", pred_taken4, m_bht[(pred_pc >> 2) % 16] >= 2);
      chk("out_valid", out_valid, m_ov);
      chk("b_out", b_out, m_b);
      chk("mispredict", mispredict, m_mis);
      chk("branch_count", branch_count, m_bc);
      chk("mispredict_count", mispredict_count, m_mc);
      chk("branch_count_w4", branch_count4, m_bc4);
      chk("mispredict_count_w4", mispredict_count4, m_mc4);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input int t, input logic [31:0] pc, input bit z, input bit n,
                     input bit o, input bit c, input bit pt);
    res_valid = 1'b1; branch_type = 3'(t); res_pc = pc;
    zf = z; nf = n; vf = o; cf = c; res_pred_taken = pt;
  endtask

  task automatic idle();
    res_valid = 1'b0; branch_type = 3'd0;
  endtask

  int   saved_bc;
  int   tv_type [6] = '{3, 5, 6, 2, 4, 1};
  bit   tv_z    [6] = '{0, 0, 0, 1, 0, 0};
  bit   tv_n    [6] = '{1, 0, 0, 0, 1, 0};
  bit   tv_o    [6] = '{1, 0, 0, 0, 1, 0};
  bit   tv_c    [6] = '{0, 0, 1, 0, 0, 0};
  bit   tv_exp  [6] = '{0, 1, 1, 0, 1, 0};

  initial begin
    nrst = 1'b0; pred_pc = 32'h0; res_pc = 32'h0; res_valid = 1'b0;
    branch_type = 3'd0; res_pred_taken = 1'b0; zf = 1'b0; nf = 1'b0;
    vf = 1'b0; cf = 1'b0; stats_clear = 1'b0;
    repeat (2) tick();
    nrst = 1'b1;

    // Reset state lookups.
    pred_pc = 32'h0;    #1 chk("lit_pred_0x0", pred_taken, 0);
    pred_pc = 32'h3C;   #1 chk("lit_pred_0x3C", pred_taken, 0);
    pred_pc = 32'hFFFC; #1 chk("lit_pred_0xFFFC", pred_taken, 0);
    chk("lit_reset_bc", branch_count, 0);
    chk("lit_reset_mc", mispredict_count, 0);

    // Train BEQ at 0x40 four times; first two predicted not-taken.
    pred_pc = 32'h40;
    for (int k = 0; k < 4; k++) begin
      res(1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, k >= 2);
      tick();
      chk("lit_train_b_out", b_out, 1);
      chk("lit_train_mispredict", mispredict, k < 2);
      chk("lit_train_pred", pred_taken, 1);
    end
    idle();
    tick();
    chk("lit_train_bc", branch_count, 4);
    chk("lit_train_mc", mispredict_count, 2);
    chk("lit_idle_out_valid", out_valid, 0);

    // Condition table, one resolve per cycle.
    for (int i = 0; i < 6; i++) begin
      res(tv_type[i], 32'h104 + 32'(4 * i), tv_z[i], tv_n[i], tv_o[i], tv_c[i], 1'b0);
      tick();
      chk("lit_cond_b_out", b_out, tv_exp[i]);
    end

    // Reserved type: valid, no outcome, no count.
    idle(); tick();
    saved_bc = int'(branch_count);
    res(7, 32'h200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("lit_rsvd_valid", out_valid, 1);
    chk("lit_rsvd_b_out", b_out, 0);
    chk("lit_rsvd_mispredict", mispredict, 0);
    chk("lit_rsvd_bc", branch_count, saved_bc);

    // Twenty resolves saturate a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      res(1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    idle(); tick();
    chk("lit_sat_bc4", branch_count4, 15);
    chk("lit_sat_bc16", branch_count, saved_bc + 20);

    // Clear beats a simultaneous mispredicting resolve.
    res(1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    chk("lit_clr_bc", branch_count, 0);
    chk("lit_clr_mc", mispredict_count, 0);
    chk("lit_clr_mc4", mispredict_count4, 0);
    chk("lit_clr_mispredict", mispredict, 1);

    // Mid-stream reset with a resolve pending.
    res(2, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    nrst = 1'b0;
    res(1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    nrst = 1'b1;
    idle();
    chk("lit_rst_out_valid", out_valid, 0);
    chk("lit_rst_b_out", b_out, 0);
    chk("lit_rst_mispredict", mispredict, 0);
    chk("lit_rst_bc", branch_count, 0);
    chk("lit_rst_mc", mispredict_count, 0);
    for (int i = 0; i < 16; i++) begin
      pred_pc = 32'(4 * i);
      #1 chk("lit_rst_pred", pred_taken, 0);
    end

    // Read-before-write at 0x80 from WNT.
    tick();
    pred_pc = 32'h80;
    res(1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("lit_rbw_same_cycle", pred_taken, 0);
    tick();
    idle();
    chk("lit_rbw_next_cycle", pred_taken, 1);
    chk("lit_post_rst_bc", branch_count, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
